// File: rtl/vga_line_fetcher.sv
// Copies one 256-pixel 8bpp scanline from main memory into the 32-bit line-buffer write port.
// Latency: 2 cycles per byte with zero-wait memory; done 513 cycles after an accepted start.
// Backpressure: each byte request is held until mem_ack; start is only honoured while idle.
module vga_line_fetcher #(
  parameter int                        MEM_ADDR_WIDTH = 16,
  parameter logic [MEM_ADDR_WIDTH-1:0] FB_BASE        = 16'h0000,
  parameter int                        LINES          = 192
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                line_num,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_rd_data,
  output logic                      wr_en,
  output logic [5:0]                wr_addr,
  output logic [31:0]               wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [7:0]                idx_q;
  logic [7:0]                idx_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [MEM_ADDR_WIDTH-1:0] line_off;
  logic [23:0]               pack_q;
  logic [7:0]                last_q;
  logic                      err_q;
  logic                      line_ok;
  logic                      accept;
  logic                      reject;
  logic                      word_end;

  // Line offset in bytes; the final address wraps modulo the address width.
  assign line_off = MEM_ADDR_WIDTH'({line_num, 8'h00});
  assign line_ok  = (int'(line_num) < LINES);
  assign word_end = (idx_q[1:0] == 2'd3);

  // State and byte-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: one request per byte, one GAP cycle after each ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (line_ok) begin
            state_d = REQ;
            idx_d   = 8'd0;
            accept  = 1'b1;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (idx_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line base latched at accept so a later line_num change cannot move the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (accept) begin
      base_q <= FB_BASE + line_off;
    end
  end

  // Byte packing: lanes 0..2 go to the pack register, lane 3 is held separately
  // and completes the word presented during the following GAP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= 24'd0;
      last_q <= 8'd0;
    end else if ((state_q == REQ) && mem_ack) begin
      case (idx_q[1:0])
        2'd0:    pack_q[7:0]   <= mem_rd_data;
        2'd1:    pack_q[15:8]  <= mem_rd_data;
        2'd2:    pack_q[23:16] <= mem_rd_data;
        default: last_q        <= mem_rd_data;
      endcase
    end
  end

  // Rejected start produces a one-cycle error pulse in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  always_comb begin
    busy     = (state_q == REQ) || (state_q == GAP);
    done     = (state_q == DONE);
    err      = err_q;
    mem_req  = (state_q == REQ);
    mem_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = 6'd0;
    wr_data  = 32'd0;
    if (state_q == REQ) begin
      mem_addr = base_q + MEM_ADDR_WIDTH'(idx_q);
    end
    if ((state_q == GAP) && word_end) begin
      wr_en   = 1'b1;
      wr_addr = idx_q[7:2];
      wr_data = {last_q, pack_q};
    end
  end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: table of line fetches plus hand-written corner sequences.
// Memory returns the low address byte, so every line packs to the same word pattern.
// Expected words are assembled from bytes returned by the memory model and queued.
module tb_vga_line_fetcher;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  line_num;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  logic        w_start;
  logic [7:0]  w_line;
  logic        w_busy;
  logic        w_done;
  logic        w_err;
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [7:0]  w_rd;
  logic        w_wr_en;
  logic [5:0]  w_wr_addr;
  logic [31:0] w_wr_data;

  vga_line_fetcher #(.MEM_ADDR_WIDTH(16), .FB_BASE(16'h0000), .LINES(192)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_num(line_num),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  vga_line_fetcher #(.MEM_ADDR_WIDTH(16), .FB_BASE(16'hC000), .LINES(192)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .line_num(w_line),
    .busy(w_busy), .done(w_done), .err(w_err),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rd_data(w_rd),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data = low address byte; ack after a random delay of 0..dly_max.
  int unsigned dly_max;
  bit          spur_en;
  int unsigned wait_cnt;
  int unsigned target;

  assign mem_ack     = mem_req ? ((dly_max == 0) || (wait_cnt >= target)) : spur_en;
  assign mem_rd_data = mem_addr[7:0];
  assign w_ack       = w_req;
  assign w_rd        = w_addr[7:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      target   <= 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      target   <= $urandom_range(dly_max, 0);
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  line;
    int          dmax;
    bit          spur;
    bit          exp_err;
    logic [31:0] w0;
    logic [31:0] w63;
    int          dcyc;
  } vec_t;

  wr_t         exp_q[$];
  vec_t        vecs[6];
  int          checks;
  int          errors;
  int          cyc;
  int          nbytes;
  int          n_wr;
  int          n_done;
  int          n_err;
  int          n_busy;
  int          n_req;
  int          done_cyc;
  int          err_cyc;
  logic [15:0] exp_base;
  logic [31:0] asm_word;
  logic [31:0] first_word;
  logic [31:0] last_word;
  logic [5:0]  first_wr_addr;
  logic        prev_req;
  logic [15:0] prev_addr;
  logic        prev_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge and run the monitor/scoreboard.
  task automatic tick();
    logic [15:0] ea;
    wr_t         e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (mem_req) begin
        n_req++;
        ea = exp_base + {8'h00, 8'(nbytes)};
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (prev_req) chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
      end
      if (mem_req && mem_ack) begin
        asm_word[8*(nbytes%4) +: 8] = mem_rd_data;
        if ((nbytes % 4) == 3) begin
          e.addr = 6'(nbytes / 4);
          e.data = asm_word;
          exp_q.push_back(e);
        end
        nbytes++;
      end
      if (wr_en) begin
        chk("wr_en_back_to_back", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
        end
        if (n_wr == 0) begin
          first_word    = wr_data;
          first_wr_addr = wr_addr;
        end
        last_word = wr_data;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (busy) n_busy++;
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_wr   = wr_en;
  endtask

  task automatic begin_line(input logic [7:0] l);
    exp_q.delete();
    nbytes = 0; asm_word = 32'd0; n_wr = 0; n_done = 0; n_err = 0;
    n_busy = 0; n_req = 0; done_cyc = -1; err_cyc = -1;
    first_word = 32'd0; last_word = 32'd0; first_wr_addr = 6'h3F;
    exp_base = {l, 8'h00};
    line_num = l;
    start    = 1'b1;
    cyc      = 0;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_line(input bit exp_err);
    for (int k = 0; k < 6000; k++) begin
      if (n_done > 0 || (exp_err && cyc >= 8)) break;
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic end_checks(input vec_t v);
    chk("n_err", 32'(n_err), 32'(v.exp_err));
    chk("n_done", 32'(n_done), v.exp_err ? 32'd0 : 32'd1);
    chk("n_writes", 32'(n_wr), v.exp_err ? 32'd0 : 32'd64);
    if (v.exp_err) begin
      chk("err_cycle", 32'(err_cyc), 32'd1);
      chk("req_on_reject", 32'(n_req), 32'd0);
      chk("busy_on_reject", 32'(n_busy), 32'd0);
    end else begin
      chk("word0", first_word, v.w0);
      chk("word63", last_word, v.w63);
      chk("first_wr_addr", 32'(first_wr_addr), 32'd0);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      if (v.dcyc >= 0) chk("done_cycle", 32'(done_cyc), 32'(v.dcyc));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(busy),     32'd0);
    chk({tag, "_done"},    32'(done),     32'd0);
    chk({tag, "_err"},     32'(err),      32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req),  32'd0);
    chk({tag, "_wr_en"},   32'(wr_en),    32'd0);
    chk({tag, "_mem_addr"},32'(mem_addr), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr),  32'd0);
    chk({tag, "_wr_data"}, wr_data,       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [15:0] w_first;
    logic [15:0] w_last;
    bit          w_seen;
    int          w_writes;
    int          w_dones;

    vecs[0] = '{8'd5,   0, 1'b0, 1'b0, 32'h03020100, 32'hFFFEFDFC, 513};
    vecs[1] = '{8'd5,   7, 1'b0, 1'b0, 32'h03020100, 32'hFFFEFDFC, -1};
    vecs[2] = '{8'd192, 0, 1'b0, 1'b1, 32'h0,        32'h0,        -1};
    vecs[3] = '{8'd191, 3, 1'b1, 1'b0, 32'h03020100, 32'hFFFEFDFC, -1};
    vecs[4] = '{8'd255, 0, 1'b1, 1'b1, 32'h0,        32'h0,        -1};
    vecs[5] = '{8'd0,   0, 1'b0, 1'b0, 32'h03020100, 32'hFFFEFDFC, 513};

    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; line_num = 8'd0;
    w_start = 1'b0; w_line = 8'd0;
    dly_max = 0; spur_en = 1'b0;
    prev_req = 1'b0; prev_addr = 16'd0; prev_wr = 1'b0;
    exp_base = 16'd0; nbytes = 0; asm_word = 32'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Table of line fetches.
    for (int r = 0; r < 6; r++) begin
      v       = vecs[r];
      dly_max = v.dmax;
      spur_en = v.spur;
      begin_line(v.line);
      wait_line(v.exp_err);
      end_checks(v);
      spur_en = 1'b0;
    end

    // Starts during a busy line are ignored; fetch stays on line 7.
    dly_max = 0;
    begin_line(8'd7);
    for (int k = 0; k < 6000; k++) begin
      if (n_done > 0) break;
      tick();
      if (cyc == 50)       begin start = 1'b1; line_num = 8'd9;   end
      else if (cyc == 200) begin start = 1'b1; line_num = 8'd200; end
      else                 start = 1'b0;
    end
    start = 1'b0;
    repeat (3) tick();
    v = '{8'd7, 0, 1'b0, 1'b0, 32'h03020100, 32'hFFFEFDFC, 513};
    end_checks(v);

    // Reset mid-line after byte 100, then refetch line 3 from byte 0.
    begin_line(8'd5);
    for (int k = 0; k < 1000; k++) begin
      if (nbytes >= 101) break;
      tick();
    end
    chk("bytes_before_reset", 32'(nbytes), 32'd101);
    chk("writes_before_reset", 32'(n_wr), 32'd25);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midline_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    begin_line(8'd3);
    wait_line(1'b0);
    v = '{8'd3, 0, 1'b0, 1'b0, 32'h03020100, 32'hFFFEFDFC, 513};
    end_checks(v);

    // Address wrap with a high framebuffer base.
    w_line = 8'd191; w_start = 1'b1;
    w_seen = 1'b0; w_writes = 0; w_dones = 0;
    w_first = 16'd0; w_last = 16'd0;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (w_req) begin
        if (!w_seen) w_first = w_addr;
        w_seen = 1'b1;
        w_last = w_addr;
      end
      if (w_wr_en) w_writes++;
      if (w_done) begin
        w_dones++;
        break;
      end
      tick();
    end
    chk("wrap_first_addr", 32'(w_first), 32'h7F00);
    chk("wrap_last_addr", 32'(w_last), 32'h7FFF);
    chk("wrap_writes", 32'(w_writes), 32'd64);
    chk("wrap_done", 32'(w_dones), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
